rv32_regfile: RTL and testbench



---
 rtl/rv32_regfile.sv | 73 +++++++
 tb/tb_rv32_regfile.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/rv32_regfile.sv
// RV32I integer register file: 2**ADDR_WIDTH x DATA_WIDTH entries, two combinational
// read ports, one synchronous write port, x0 hardwired to zero.
module rv32_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int WR_BYPASS  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  regs_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
  output logic [DATA_WIDTH-1:0] rs1_data_o,
  output logic [DATA_WIDTH-1:0] rs2_data_o
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_sel;

  // One-hot write select; bit 0 stays low so x0 can never be stored.
  assign wr_sel[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_wr_sel
    assign wr_sel[gi] = regs_wr_en_i && (rd_addr_i == ADDR_WIDTH'(gi));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_sel[i]) begin
          regs_reg[i] <= rd_data_i;
        end
      end
    end
  end

  logic [ADDR_WIDTH-1:0] rs_addr [2];
  assign rs_addr[0] = rs1_addr_i;
  assign rs_addr[1] = rs2_addr_i;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
    logic [DATA_WIDTH-1:0] port_data;
    logic                  collide;

    assign collide = (WR_BYPASS != 0) && regs_wr_en_i && (rd_addr_i == rs_addr[gi]);

    // Reset and x0 both force zero; bypass only matters for non-zero addresses.
    always_comb begin
      port_data = '0;
      if (!rst_i && (rs_addr[gi] != '0)) begin
        if (collide) begin
          port_data = rd_data_i;
        end else begin
          port_data = regs_reg[rs_addr[gi]];
        end
      end
    end

    if (gi == 0) begin : g_p1
      assign rs1_data_o = port_data;
    end else begin : g_p2
      assign rs2_data_o = port_data;
    end
  end

endmodule

// File: tb/tb_rv32_regfile.sv
// Randomized scoreboard bench for rv32_regfile; checks both bypass variants in lockstep
// against an array-based model of the architectural register state.
module tb_rv32_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_nb, rs2_nb, rs1_bp, rs2_bp;

  rv32_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WR_BYPASS(0)) dut_nb (
    .clk_i(clk), .rst_i(rst), .regs_wr_en_i(we), .rd_addr_i(rd_addr), .rd_data_i(rd_data),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr), .rs1_data_o(rs1_nb), .rs2_data_o(rs2_nb)
  );

  rv32_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WR_BYPASS(1)) dut_bp (
    .clk_i(clk), .rst_i(rst), .regs_wr_en_i(we), .rd_addr_i(rd_addr), .rd_data_i(rd_data),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr), .rs1_data_o(rs1_bp), .rs2_data_o(rs2_bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] e1_nb;
    logic [31:0] e2_nb;
    logic [31:0] e1_bp;
    logic [31:0] e2_bp;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [32];
  int          checks = 0;
  int          errors = 0;
  int          step_id = 0;
  bit          done = 1'b0;

  // Architectural read as seen before the edge.
  function automatic logic [31:0] model_read(input logic [4:0] a, input bit bypass);
    if (rst || a == 5'd0) return 32'h0;
    if (bypass && we && rd_addr == a) return rd_data;
    return model_mem[a];
  endfunction

  task automatic check(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %08h expected %08h", name, id, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit w, input logic [4:0] rd, input logic [31:0] wd,
                      input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    rst = r; we = w; rd_addr = rd; rd_data = wd; rs1_addr = a1; rs2_addr = a2;
    e.id    = step_id;
    e.e1_nb = model_read(a1, 1'b0);
    e.e2_nb = model_read(a2, 1'b0);
    e.e1_bp = model_read(a1, 1'b1);
    e.e2_bp = model_read(a2, 1'b1);
    exp_q.push_back(e);
    $display("step %0d rst=%0b we=%0b rd=x%0d wd=%08h rs1=x%0d rs2=x%0d", step_id, r, w, rd,
             wd, a1, a2);
    step_id++;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
    end else if (w && rd != 5'd0) begin
      model_mem[rd] = wd;
    end
    #1;
  endtask

  // Monitor: outputs are combinational, so each cycle's result is sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("rs1_nobypass", e.id, rs1_nb, e.e1_nb);
      check("rs2_nobypass", e.id, rs2_nb, e.e2_nb);
      check("rs1_bypass",   e.id, rs1_bp, e.e1_bp);
      check("rs2_bypass",   e.id, rs2_bp, e.e2_bp);
    end
  end

  initial begin
    rst = 1'b1; we = 1'b0; rd_addr = '0; rd_data = '0; rs1_addr = '0; rs2_addr = '0;
    for (int i = 0; i < 32; i++) model_mem[i] = 32'hx;
    @(posedge clk);
    #1;
    step(1, 0, 0, 32'h0, 2, 5);
    step(0, 1, 2, 32'hABCDABCD, 2, 5);
    step(0, 0, 0, 32'h0, 2, 5);
    step(0, 1, 5, 32'hAAAAAAAA, 2, 5);
    step(0, 0, 0, 32'h0, 2, 5);
    step(0, 1, 0, 32'hFFFFFFFF, 0, 0);
    step(0, 0, 0, 32'h0, 0, 0);
    step(0, 0, 2, 32'h12345678, 2, 5);
    step(0, 0, 0, 32'h0, 2, 5);
    step(1, 1, 2, 32'h55555555, 2, 5);
    step(0, 0, 0, 32'h0, 2, 5);
    step(0, 1, 7, 32'h11111111, 3, 4);
    step(0, 1, 7, 32'h22222222, 7, 7);
    step(0, 0, 0, 32'h0, 7, 0);
    for (int n = 0; n < 400; n++) begin
      bit r;
      bit w;
      logic [4:0]  rd;
      logic [31:0] wd;
      logic [4:0]  a1;
      logic [4:0]  a2;
      r  = ($urandom_range(0, 39) == 0);
      w  = $urandom_range(0, 1) != 0;
      rd = 5'($urandom_range(0, 31));
      wd = $urandom();
      a1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      step(r, w, rd, wd, a1, a2);
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      errors++;
      $display("FAIL timeout: got step %0d expected completion", step_id);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

endmodule
